// File: rtl/fetch_pkg.sv
// fetch_pkg: shared pipeline encodings for the RV32I fetch stage and its pipeline registers.
package fetch_pkg;
  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush > load > stall > bubble priority.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_load,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);
  logic        r_valid;
  logic [31:0] r_instr, r_pc, r_pc4;
  // Bubbles leave the PC fields untouched; only valid/instr are meaningful then.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_flush || (!i_load && !i_stall)) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc + 32'd4;
    end
  end
  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC select, single-outstanding imem request and IF/ID register.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        Fi_stall,
  input  logic        Di_stall,
  input  logic        Di_flush,
  input  logic [1:0]  Ei_PCSrc,
  input  logic [31:0] Ei_branchTarget,
  input  logic [31:0] Ei_jalrTarget,
  output logic        Fo_imemReq,
  output logic [31:0] Fo_imemAddr,
  input  logic        Fi_imemRvalid,
  input  logic [31:0] Fi_imemRdata,
  output logic        Do_valid,
  output logic [31:0] Do_instr,
  output logic [31:0] Do_PC,
  output logic [31:0] Do_PCPlus4,
  output logic        Fo_busy
);
  fetch_state_t r_state, w_state_nxt;
  logic [31:0] r_pc, r_addr, r_skid_instr, r_skid_pc, w_pc_nxt, w_target;
  logic r_kill, w_kill_nxt, w_redir, w_go, w_wait, w_hold;
  logic w_ld_wait, w_ld_hold, w_load, w_capture;
  assign w_redir   = Ei_PCSrc != PCSRC_PLUS4;
  assign w_target  = Ei_PCSrc == PCSRC_JALR ? Ei_jalrTarget : Ei_branchTarget;
  assign w_go      = !Di_stall && !Fi_stall && !w_redir;
  assign w_wait    = r_state == S_WAIT;
  assign w_hold    = r_state == S_HOLD;
  assign w_ld_wait = w_wait && Fi_imemRvalid && !r_kill && w_go;
  assign w_ld_hold = w_hold && w_go;
  assign w_load    = w_ld_wait || w_ld_hold;
  assign w_capture = w_wait && Fi_imemRvalid && !r_kill && !w_redir && !w_go;
  always_comb begin
    w_state_nxt = (w_capture || (w_hold && !w_redir && !w_go)) ? S_HOLD : S_WAIT;
    w_kill_nxt  = w_wait ? (Fi_imemRvalid ? 1'b0 : (r_kill || w_redir)) : r_kill;
    w_pc_nxt    = w_redir ? w_target : w_load ? r_pc + 32'd4 : r_pc;
  end
  // The outstanding address stays put until its data returns, even across a redirect.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_addr       <= RESET_PC;
      r_kill       <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= (w_wait && !Fi_imemRvalid) ? r_addr : w_pc_nxt;
      r_kill  <= w_kill_nxt;
      if (w_capture) begin
        r_skid_instr <= Fi_imemRdata;
        r_skid_pc    <= r_pc;
      end
    end
  end
  assign Fo_imemReq  = w_wait;
  assign Fo_imemAddr = r_addr;
  assign Fo_busy     = w_wait && !Fi_imemRvalid;
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .reset_x (reset_x),
    .i_load  (w_load),
    .i_stall (Di_stall && !w_redir),
    .i_flush (Di_flush),
    .i_instr (w_ld_hold ? r_skid_instr : Fi_imemRdata),
    .i_pc    (w_ld_hold ? r_skid_pc : r_pc),
    .o_valid (Do_valid),
    .o_instr (Do_instr),
    .o_pc    (Do_PC),
    .o_pc4   (Do_PCPlus4)
  );
endmodule
